crc8_frame_checker: RTL and testbench
=====================================

# crc8_frame_checker

Receive-side CRC-8 checker for the trigger byte link. It consumes a byte stream in which each frame ends with its CRC-8 byte, as appended by the transmit side. The CRC uses polynomial 0x07, init 0x00, no reflection and no final XOR. The checker computes the running CRC at one byte per cycle, then reports one status word per frame (pass/fail, payload length) over a valid/ready handshake to the trigger control logic.

## Interface
- `LEN_W`, default 8: width of the payload-length counter and `m_len`.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_data` in 8: received byte.
- `s_valid` in 1: `s_data` is valid.
- `s_last` in 1: this byte is the frame's CRC byte (final beat).
- `s_ready` out 1: the checker accepts a byte this cycle.
- `m_valid` out 1: frame status is available.
- `m_ready` in 1: the consumer takes the status.
- `m_ok` out 1: the frame's CRC matched.
- `m_len` out LEN_W: payload byte count, which excludes the CRC byte.
- `m_len_sat` out 1: the payload length exceeded 2^LEN_W-1, so `m_len` is saturated.
- `err_count` out 16: only present with `CRC8_ERR_COUNT_EN`.

## Operation
- **State machine:** `IDLE`, `RECV`, `REPORT`.
- **Accept rule:** a beat is accepted when `s_valid && s_ready`. `s_ready = 1` in `IDLE` and `RECV`; `s_ready = 0` in `REPORT`.
- **CRC update per accepted beat:** `crc <= T[crc ^ s_data]`, where `T` is the CRC-8/0x07 byte table (T[0x00]=0x00, T[0x01]=0x07, T[0x80]=0x89, T[0xFF]=0xF3). The table is instantiated internally as combinational logic.
- **Check rule:** the CRC byte is fed through the same update. A good frame leaves `crc == 0x00` after the last beat.
- **Transitions:**
  - `IDLE`: an accepted non-last beat moves to `RECV`; an accepted last beat moves to `REPORT`.
  - `RECV`: an accepted last beat moves to `REPORT`.
  - `REPORT`: `m_valid && m_ready` moves to `IDLE`.
- **Length counter:** counts accepted non-last beats and saturates at 2^LEN_W-1. Once the count would exceed that, `m_len_sat` is set; it is sticky for the frame.
- **Outputs in `REPORT`:**
  - `m_ok = (crc_after_last == 0x00) && !m_len_sat`.
  - `m_len`, `m_ok` and `m_len_sat` stay stable while `m_valid` is high.
- **Clearing:** on leaving `REPORT`, the CRC and length counter are cleared to 0.
- **Zero-length payload:** `s_last` on the first beat gives `m_len = 0`, and `m_ok = (s_data == 0x00)`.
- **Ignored inputs:** `s_data` and `s_last` are ignored when `s_valid = 0`. No frame timeout exists; an idle gap mid-frame simply holds state.

## Timing
- **Reset values:** `s_ready = 1`, `m_valid = 0`, `m_ok = 0`, `m_len = 0`, `m_len_sat = 0`, `err_count = 0`; state `IDLE`, CRC 0x00.
- **Reset mid-frame:** the partial frame is discarded, no status is emitted, and the next accepted byte starts a fresh frame.
- **Throughput:** one byte per cycle while in `IDLE`/`RECV`.
- **Status latency:** `m_valid` rises on the cycle after the last beat is accepted.
- **Back-pressure:** `m_valid` holds until `m_ready`. `s_ready` returns to 1 on the cycle after the handshake, so the minimum gap between frames is one bubble cycle.
- **Handshake in the first report cycle:** if `m_ready` is already high, status is consumed in that single cycle.

## Configuration
- **`CRC8_ERR_COUNT_EN` defined:**
  - `err_count` port and logic are present.
  - The 16-bit counter increments by 1 on each status handshake with `m_ok = 0`, and saturates at 0xFFFF.
  - Cleared only by `rst`.
- **`CRC8_ERR_COUNT_EN` undefined:** the port and logic are absent; all other behaviour is identical.

## Test plan
- **Known-answer frame:** ASCII "123456789" (0x31..0x39) then 0xF4, back-to-back, `m_ready = 1` → `m_valid` one cycle after the last beat, `m_ok = 1`, `m_len = 9`, `m_len_sat = 0`.
- **Single-byte payload and corruption:** frame {0x01, 0x07} → `m_ok = 1`, `m_len = 1`. Frame {0x01, 0x08} → `m_ok = 0`, `m_len = 1`, and `err_count` increments to 1 when enabled.
- **Back-pressure:** hold `m_ready = 0` for 5 cycles after the report → `s_ready = 0` and the status is stable throughout. Then `m_ready = 1` → `s_ready = 1` on the next cycle, and the following frame is checked with the CRC cleared.
- **Zero-length and saturation:** a lone last beat 0x00 → `m_ok = 1`, `m_len = 0`. With `LEN_W = 2`, a 4-byte payload with a correct CRC → `m_len = 3`, `m_len_sat = 1`, `m_ok = 0`.
- **Reset mid-frame:** assert `rst` after 3 payload bytes, then send {0x01, 0x07} → no status for the aborted frame; `m_ok = 1`, `m_len = 1`.
- **Stalls and idle gaps:** randomly toggle `s_valid` inside the "123456789"+0xF4 frame → same result as the known-answer frame.

Source files
------------

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 (poly 0x07, init 0, no reflect/xorout) frame checker; one status word per frame.
// Optional 16-bit failed-frame counter enabled by defining CRC8_ERR_COUNT_EN.
module crc8_frame_checker #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_ok,
  output logic [LEN_W-1:0] m_len,
  output logic             m_len_sat
`ifdef CRC8_ERR_COUNT_EN
  ,output logic [15:0]     err_count
`endif
);

  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_t           state_q, state_d;
  logic [7:0]       crc_q, crc_d, crc_tab;
  logic [LEN_W-1:0] len_q, len_d;
  logic             sat_q, sat_d;
  logic             accept, hs;

  // One table lookup, T[x], built as eight shift/xor steps of the MSB-first CRC.
  function automatic logic [7:0] crc8_tab(input logic [7:0] x);
    logic [7:0] c;
    c = x;
    for (int i = 0; i < 8; i++)
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  assign crc_tab = crc8_tab(crc_q ^ s_data);
  assign accept  = s_valid && s_ready;
  assign hs      = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = s_last ? REPORT : RECV;
      RECV:    if (accept && s_last) state_d = REPORT;
      REPORT:  if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = (state_q != REPORT);
    m_valid   = (state_q == REPORT);
    m_ok      = m_valid && (crc_q == 8'h00) && !sat_q;
    m_len     = m_valid ? len_q : '0;
    m_len_sat = m_valid && sat_q;
  end

  // The CRC byte runs through the same update, so a good frame ends at zero.
  always_comb begin
    crc_d = crc_q;
    len_d = len_q;
    sat_d = sat_q;
    if (hs) begin
      crc_d = 8'h00;
      len_d = '0;
      sat_d = 1'b0;
    end else if (accept) begin
      crc_d = crc_tab;
      if (!s_last) begin
        if (len_q == LEN_MAX) sat_d = 1'b1;
        else                  len_d = len_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= 8'h00;
      len_q <= '0;
      sat_q <= 1'b0;
    end else begin
      crc_q <= crc_d;
      len_q <= len_d;
      sat_q <= sat_d;
    end
  end

`ifdef CRC8_ERR_COUNT_EN
  logic [15:0] err_q;
  always_ff @(posedge clk) begin
    if (rst)                                   err_q <= 16'h0000;
    else if (hs && !m_ok && err_q != 16'hFFFF) err_q <= err_q + 16'h0001;
  end
  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Directed bench for crc8_frame_checker: default-width DUT plus a LEN_W=2 DUT on the same stream.
module tb_crc8_frame_checker;

  logic       clk = 1'b0;
  logic       rst, s_valid, s_last, m_ready;
  logic [7:0] s_data;
  logic       s_ready, m_valid, m_ok, m_len_sat;
  logic [7:0] m_len;
  logic       s_ready2, m_valid2, m_ok2, m_len_sat2;
  logic [1:0] m_len2;
`ifdef CRC8_ERR_COUNT_EN
  logic [15:0] err_count, err_count2;
`endif
  int n_chk = 0, n_pass = 0;
  int exp_err = 0, exp_err2 = 0;
  logic [7:0] kat [10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};

  always #5 clk = ~clk;

  crc8_frame_checker #(.LEN_W(8)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready), .m_ok(m_ok),
    .m_len(m_len), .m_len_sat(m_len_sat)
`ifdef CRC8_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  crc8_frame_checker #(.LEN_W(2)) dut2 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready2), .m_valid(m_valid2), .m_ready(m_ready), .m_ok(m_ok2),
    .m_len(m_len2), .m_len_sat(m_len_sat2)
`ifdef CRC8_ERR_COUNT_EN
    , .err_count(err_count2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Drive one beat; returns 1 time unit after the accepting edge.
  task automatic beat(input logic [7:0] d, input logic last);
    s_valid = 1'b1; s_data = d; s_last = last;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic status(input string tag, input logic ok, input logic [7:0] len, input logic sat);
    chk({tag, ".m_valid"}, m_valid, 1'b1);
    chk({tag, ".m_ok"}, m_ok, ok);
    chk({tag, ".m_len"}, m_len, len);
    chk({tag, ".m_len_sat"}, m_len_sat, sat);
  endtask

  task automatic status2(input string tag, input logic ok, input logic [1:0] len, input logic sat);
    chk({tag, ".m_ok2"}, m_ok2, ok);
    chk({tag, ".m_len2"}, m_len2, len);
    chk({tag, ".m_len_sat2"}, m_len_sat2, sat);
  endtask

  task automatic check_err(input string tag);
`ifdef CRC8_ERR_COUNT_EN
    chk({tag, ".err_count"}, err_count, exp_err);
    chk({tag, ".err_count2"}, err_count2, exp_err2);
`endif
  endtask

  // With m_ready high the status is taken in the first report cycle.
  task automatic drain(input string tag);
    @(posedge clk); #1;
    chk({tag, ".drain_m_valid"}, m_valid, 1'b0);
    chk({tag, ".drain_s_ready"}, s_ready, 1'b1);
    check_err(tag);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.s_ready", s_ready, 1'b1);
    chk("rst.m_valid", m_valid, 1'b0);
    chk("rst.m_ok", m_ok, 1'b0);
    chk("rst.m_len", m_len, 8'd0);
    chk("rst.m_len_sat", m_len_sat, 1'b0);
    check_err("rst");
    rst = 1'b0;

    // Known-answer "123456789" + 0xF4; LEN_W=2 instance saturates on 9 bytes.
    for (int i = 0; i < 10; i++) beat(kat[i], i == 9);
    status("kat", 1'b1, 8'd9, 1'b0);
    status2("kat", 1'b0, 2'd3, 1'b1);
    exp_err2++;
    drain("kat");

    beat(8'h01, 1'b0); beat(8'h07, 1'b1);
    status("one_ok", 1'b1, 8'd1, 1'b0);
    drain("one_ok");

    // Corrupt frame held under back-pressure.
    m_ready = 1'b0;
    beat(8'h01, 1'b0); beat(8'h08, 1'b1);
    for (int i = 0; i < 5; i++) begin
      status("bp", 1'b0, 8'd1, 1'b0);
      chk("bp.s_ready", s_ready, 1'b0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    exp_err++; exp_err2++;
    drain("bp");
    beat(8'h01, 1'b0); beat(8'h07, 1'b1);
    status("after_bp", 1'b1, 8'd1, 1'b0);
    drain("after_bp");

    beat(8'h00, 1'b1);
    status("zero_ok", 1'b1, 8'd0, 1'b0);
    drain("zero_ok");
    beat(8'h05, 1'b1);
    status("zero_bad", 1'b0, 8'd0, 1'b0);
    exp_err++; exp_err2++;
    drain("zero_bad");

    // 4-byte payload with a correct CRC.
    beat(8'h00, 1'b0); beat(8'h00, 1'b0); beat(8'h00, 1'b0); beat(8'h01, 1'b0);
    beat(8'h07, 1'b1);
    status("sat", 1'b1, 8'd4, 1'b0);
    status2("sat", 1'b0, 2'd3, 1'b1);
    exp_err2++;
    drain("sat");

    // Reset mid-frame discards the partial frame and the error counter.
    beat(8'h31, 1'b0); beat(8'h32, 1'b0); beat(8'h33, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err = 0; exp_err2 = 0;
    chk("midrst.m_valid", m_valid, 1'b0);
    chk("midrst.s_ready", s_ready, 1'b1);
    check_err("midrst");
    beat(8'h01, 1'b0); beat(8'h07, 1'b1);
    status("midrst", 1'b1, 8'd1, 1'b0);
    drain("midrst");

    // Known-answer frame with random idle gaps carrying junk data/last.
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 2)) begin
        s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
        @(posedge clk); #1;
        chk("stall.m_valid", m_valid, 1'b0);
      end
      beat(kat[i], i == 9);
    end
    status("stall", 1'b1, 8'd9, 1'b0);
    exp_err2++;
    drain("stall");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
